// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register map, empty-vector code
// and control-register bit positions.
package irq_pkg;
  localparam logic [2:0] REG_RAW   = 3'd0;
  localparam logic [2:0] REG_PEND  = 3'd1;
  localparam logic [2:0] REG_MASK  = 3'd2;
  localparam logic [2:0] REG_MODE  = 3'd3;
  localparam logic [2:0] REG_POL   = 3'd4;
  localparam logic [2:0] REG_VEC   = 3'd5;
  localparam logic [2:0] REG_FORCE = 3'd6;
  localparam logic [2:0] REG_CTRL  = 3'd7;

  localparam logic [7:0] VEC_NONE  = 8'h80;
  localparam int         CTRL_GEN  = 0;
endpackage

// File: rtl/irq_ctrl_if.sv
// CPU register bus as seen by the interrupt controller; the decoder/CPU side is
// the master, the controller is the slave.
interface irq_ctrl_if;
  logic       cs;
  logic       rw;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output cs, rw, addr, data_in, input data_out);
  modport slave  (input cs, rw, addr, data_in, output data_out);
endinterface

// File: rtl/irq_sync.sv
// One-bit multi-flop synchroniser for an asynchronous interrupt source.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clock) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], d};
  end

  assign q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: synchronised sources, per-channel polarity,
// mask and edge/level mode, W1C pending, software force and a priority vector.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] src,
  irq_ctrl_if.slave           bus,
  output logic                irq_n,
  output logic                vec_valid
);
  logic [CHANNELS-1:0] r_hist, r_pend, r_mask, r_mode, r_pol;
  logic                r_gen;

  logic [CHANNELS-1:0] w_sync, w_act, w_rise, w_pe, w_wdata;
  logic [CHANNELS-1:0] w_w1c, w_force, w_mode_chg, w_pol_nxt, w_pend_nxt;
  logic                w_wr;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (src[g]),
      .q     (w_sync[g])
    );
  end

  function automatic logic [7:0] ext(input logic [CHANNELS-1:0] v);
    logic [7:0] r;
    r = '0;
    r[CHANNELS-1:0] = v;
    return r;
  endfunction

  // Lowest-numbered enabled pending channel wins.
  function automatic logic [7:0] prio_vec(input logic [CHANNELS-1:0] pe);
    logic [7:0] v;
    v = VEC_NONE;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (pe[i]) v = 8'(i);
    return v;
  endfunction

  assign w_wr       = ~bus.cs & ~bus.rw;
  assign w_wdata    = bus.data_in[CHANNELS-1:0];
  assign w_act      = w_sync ^ r_pol;
  assign w_rise     = w_act & ~r_hist;
  assign w_pe       = r_pend & r_mask;
  assign w_w1c      = (w_wr && bus.addr == REG_PEND)  ? w_wdata : '0;
  assign w_force    = (w_wr && bus.addr == REG_FORCE) ? w_wdata : '0;
  assign w_mode_chg = (w_wr && bus.addr == REG_MODE)  ? (w_wdata ^ r_mode) : '0;
  assign w_pol_nxt  = (w_wr && bus.addr == REG_POL)   ? w_wdata : r_pol;

  // Edge channels latch until W1C (a fresh edge beats the clear); level channels
  // follow act; a mode change drops the channel's pending state.
  assign w_pend_nxt = ((r_mode & ((r_pend & ~w_w1c) | w_rise)) |
                       (~r_mode & w_act) | w_force) & ~w_mode_chg;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist    <= '0;
      r_pend    <= '0;
      r_mask    <= '0;
      r_mode    <= '0;
      r_pol     <= '1;
      r_gen     <= 1'b0;
      irq_n     <= 1'b1;
      vec_valid <= 1'b0;
    end else begin
      // History is taken under the polarity in force next cycle, so a POL
      // rewrite never looks like an edge.
      r_hist    <= w_sync ^ w_pol_nxt;
      r_pend    <= w_pend_nxt;
      r_pol     <= w_pol_nxt;
      irq_n     <= ~(r_gen & |w_pe);
      vec_valid <= |w_pe;
      if (w_wr) begin
        case (bus.addr)
          REG_MASK: r_mask <= w_wdata;
          REG_MODE: r_mode <= w_wdata;
          REG_CTRL: r_gen  <= bus.data_in[CTRL_GEN];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (bus.addr)
      REG_RAW:  bus.data_out = ext(w_act);
      REG_PEND: bus.data_out = ext(r_pend);
      REG_MASK: bus.data_out = ext(r_mask);
      REG_MODE: bus.data_out = ext(r_mode);
      REG_POL:  bus.data_out = ext(r_pol);
      REG_VEC:  bus.data_out = prio_vec(w_pe);
      REG_CTRL: bus.data_out[CTRL_GEN] = r_gen;
      default:  bus.data_out = '0;
    endcase
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Drives an 8-channel and a 3-channel controller from one bus and compares both
// against a register-level reference model through an expectation queue.
module tb_irq_ctrl;
  import irq_pkg::*;
  localparam int SS = 2;

  typedef struct {
    logic [7:0] d0, d1;
    logic       i0, i1, v0, v1;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] t_src = 8'hFF;
  logic       t_cs = 1'b1, t_rw = 1'b1;
  logic [2:0] t_addr = 3'd0;
  logic [7:0] t_din = 8'h00;
  logic       irq8, vv8, irq3, vv3;

  int checks = 0, errors = 0, cyc_n = 0;
  exp_t expq[$];

  irq_ctrl_if bus8 ();
  irq_ctrl_if bus3 ();
  assign bus8.cs = t_cs;  assign bus8.rw = t_rw;  assign bus8.addr = t_addr;  assign bus8.data_in = t_din;
  assign bus3.cs = t_cs;  assign bus3.rw = t_rw;  assign bus3.addr = t_addr;  assign bus3.data_in = t_din;

  irq_ctrl #(.CHANNELS(8), .SYNC_STAGES(SS)) u_dut8 (
    .clock(clk), .reset(rst), .src(t_src), .bus(bus8), .irq_n(irq8), .vec_valid(vv8));
  irq_ctrl #(.CHANNELS(3), .SYNC_STAGES(SS)) u_dut3 (
    .clock(clk), .reset(rst), .src(t_src[2:0]), .bus(bus3), .irq_n(irq3), .vec_valid(vv3));

  always #5 clk = ~clk;

  // Reference model: register contents per instance plus a history of the raw
  // source bus; the synchronised view is simply the sample taken SS edges ago.
  logic [7:0] m_pend[2], m_mask[2], m_mode[2], m_pol[2], m_hist[2];
  logic       m_ctrl[2], m_irqn[2], m_vv[2];
  logic [7:0] shist[$];

  function automatic logic [7:0] chm(int k);
    return (k == 0) ? 8'hFF : 8'h07;
  endfunction

  function automatic logic [7:0] sync_out();
    if (shist.size() >= SS) return shist[shist.size() - SS];
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_dout(int k, logic [2:0] a);
    logic [7:0] pm, r;
    pm = m_pend[k] & m_mask[k];
    r = 8'h00;
    case (a)
      3'd0: r = (sync_out() ^ m_pol[k]) & chm(k);
      3'd1: r = m_pend[k];
      3'd2: r = m_mask[k];
      3'd3: r = m_mode[k];
      3'd4: r = m_pol[k];
      3'd5: begin
        r = VEC_NONE;
        for (int i = 0; i < 8; i++)
          if (pm[i]) begin r = 8'(i); break; end
      end
      3'd7: r = {7'b0, m_ctrl[k]};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic model_step();
    logic [7:0] sy, act, np, w1c, frc, mchg;
    bit wr;
    if (rst) begin
      shist.delete();
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = 0; m_mask[k] = 0; m_mode[k] = 0; m_pol[k] = chm(k);
        m_hist[k] = 0; m_ctrl[k] = 0; m_irqn[k] = 1; m_vv[k] = 0;
      end
    end else begin
      sy = sync_out();
      wr = !t_cs && !t_rw;
      for (int k = 0; k < 2; k++) begin
        act  = (sy ^ m_pol[k]) & chm(k);
        w1c  = (wr && t_addr == 3'd1) ? t_din : 8'h00;
        frc  = (wr && t_addr == 3'd6) ? t_din : 8'h00;
        mchg = (wr && t_addr == 3'd3) ? ((t_din & chm(k)) ^ m_mode[k]) : 8'h00;
        np = 8'h00;
        for (int i = 0; i < 8; i++) begin
          if (m_mode[k][i])
            np[i] = (m_pend[k][i] && !w1c[i]) || (act[i] && !m_hist[k][i]) || frc[i];
          else
            np[i] = act[i] || frc[i];
          if (mchg[i]) np[i] = 1'b0;
        end
        m_irqn[k] = !(m_ctrl[k] && ((m_pend[k] & m_mask[k]) != 0));
        m_vv[k]   = ((m_pend[k] & m_mask[k]) != 0);
        m_pend[k] = np & chm(k);
        if (wr) begin
          case (t_addr)
            3'd2: m_mask[k] = t_din & chm(k);
            3'd3: m_mode[k] = t_din & chm(k);
            3'd4: m_pol[k]  = t_din & chm(k);
            3'd7: m_ctrl[k] = t_din[0];
            default: ;
          endcase
        end
        m_hist[k] = (sy ^ m_pol[k]) & chm(k);
      end
      shist.push_back(t_src);
      while (shist.size() > SS) shist.delete(0);
    end
  endtask

  // One bus cycle: drive inputs, queue what the outputs must show, take the edge.
  task automatic cyc(input logic c_cs, input logic c_rw, input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    t_cs = c_cs; t_rw = c_rw; t_addr = a; t_din = d;
    e.d0 = m_dout(0, a); e.d1 = m_dout(1, a);
    e.i0 = m_irqn[0]; e.i1 = m_irqn[1]; e.v0 = m_vv[0]; e.v1 = m_vv[1];
    e.cyc = cyc_n;
    expq.push_back(e);
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d); cyc(1'b0, 1'b0, a, d); endtask
  task automatic rd(input logic [2:0] a); cyc(1'b0, 1'b1, a, 8'h00); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 3'($urandom_range(0, 7)), 8'($urandom));
  endtask
  task automatic rd_all();
    for (int a = 0; a < 8; a++) rd(3'(a));
  endtask

  task automatic chk(input string name, input int c, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("dout8", e.cyc, bus8.data_out, e.d0);
      chk("dout3", e.cyc, bus3.data_out, e.d1);
      chk("irq_n8", e.cyc, {7'b0, irq8}, {7'b0, e.i0});
      chk("irq_n3", e.cyc, {7'b0, irq3}, {7'b0, e.i1});
      chk("vec_valid8", e.cyc, {7'b0, vv8}, {7'b0, e.v0});
      chk("vec_valid3", e.cyc, {7'b0, vv3}, {7'b0, e.v1});
    end
  end

  initial begin
    @(posedge clk); model_step(); #1;
    cyc(1'b1, 1'b1, REG_PEND, 8'h00);
    rst = 1'b0;
    idle(4);
    rd_all();

    // level, channel 2
    wr(REG_CTRL, 8'h01); wr(REG_MASK, 8'h04);
    t_src[2] = 1'b0;
    idle(5); rd(REG_VEC);
    wr(REG_PEND, 8'h04); rd(REG_PEND); rd(REG_PEND);
    t_src[2] = 1'b1;
    for (int i = 0; i < 5; i++) rd(REG_PEND);

    // edge, channel 5
    wr(REG_MODE, 8'h20); wr(REG_MASK, 8'h20);
    t_src[5] = 1'b0; idle(3); t_src[5] = 1'b1;
    idle(4); rd(REG_PEND);
    wr(REG_PEND, 8'h20); rd(REG_PEND); rd(REG_VEC);
    t_src[5] = 1'b0; idle(2); wr(REG_PEND, 8'h20); t_src[5] = 1'b1;
    rd(REG_PEND); idle(3); rd(REG_PEND);
    wr(REG_PEND, 8'h20); idle(2);

    // priority with global enable off, then on
    wr(REG_CTRL, 8'h00); wr(REG_MODE, 8'h30); wr(REG_MASK, 8'h30);
    wr(REG_FORCE, 8'h30); rd(REG_VEC); rd(REG_VEC);
    wr(REG_CTRL, 8'h01); rd(REG_VEC); rd(REG_VEC);
    wr(REG_PEND, 8'h10); rd(REG_VEC); wr(REG_PEND, 8'h20); idle(2);

    // mode switch, channel 1 held active
    wr(REG_MODE, 8'h02); wr(REG_MASK, 8'h02);
    t_src[1] = 1'b0; idle(4); rd(REG_PEND);
    wr(REG_MODE, 8'h00); rd(REG_PEND); rd(REG_PEND); rd(REG_PEND);
    wr(REG_MODE, 8'h02); rd(REG_PEND); rd(REG_PEND); rd(REG_PEND);
    wr(REG_POL, 8'hFD); rd(REG_RAW); rd(REG_PEND); rd(REG_PEND);
    wr(REG_POL, 8'hFF); t_src[1] = 1'b1; idle(4); wr(REG_PEND, 8'hFF);

    // out-of-range bits on the 3-channel build
    wr(REG_MODE, 8'h00);
    wr(REG_MASK, 8'hFF); rd(REG_MASK);
    wr(REG_MODE, 8'hFF); rd(REG_MODE);
    wr(REG_POL, 8'hFF);  rd(REG_POL);
    wr(REG_FORCE, 8'hF8); rd(REG_PEND); rd(REG_VEC);
    wr(REG_CTRL, 8'hFF); rd(REG_CTRL);

    // reset wins over a simultaneous write
    rst = 1'b1; wr(REG_MASK, 8'hFF); wr(REG_POL, 8'h00);
    rst = 1'b0; rd_all(); idle(3); rd_all();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) t_src[$urandom_range(0, 7)] ^= 1'b1;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 0) idle(1);
      else cyc(1'b0, 1'($urandom), 3'($urandom), 8'($urandom));
    end
    rst = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
